// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, data width and parity helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        START_BIT  = 3'b001,
        DATA_BIT   = 3'b010,
        STOP_BIT   = 3'b011,
        PARITY_BIT = 3'b100,
        CLEANUP    = 3'b101
    } uart_state_t;

    // Parity bit a transmitter would send for this data; odd sense inverts it.
    function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop RX synchronizer, resets to line-idle (1)
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync,
    output logic o_Settled
);

    logic [1:0] r_Sync;
    logic [1:0] r_Settle;

    // o_Settled marks the point where o_Sync reflects the line rather than the reset value.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Sync   <= 2'b11;
            r_Settle <= 2'b00;
        end else begin
            r_Sync   <= {r_Sync[0], i_Async};
            r_Settle <= {r_Settle[0], 1'b1};
        end
    end

    assign o_Sync    = r_Sync[1];
    assign o_Settled = r_Settle[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8 data bits LSB first, 1 stop; parity via UART_RX_PARITY_EN
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int PARITY_ODD   = 0
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_RX_Serial,
    output logic [UART_DATA_BITS-1:0] o_Output_Byte,
    output logic                      o_RX_Valid,
    output logic                      o_Main_RX_Active,
    output logic                      o_Frame_Error,
    output logic                      o_Parity_Error
);

    localparam logic [15:0] HALF_BIT   = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_INDEX = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx: parameter out of range");
    end

    logic w_RX_Sync;
    logic w_Sync_Settled;

    uart_rx_sync u_sync (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Async   (i_RX_Serial),
        .o_Sync    (w_RX_Sync),
        .o_Settled (w_Sync_Settled)
    );

    uart_state_t               r_State, w_Next_State;
    logic [15:0]               r_Clock_Count, w_Next_Count;
    logic [2:0]                r_Bit_Index, w_Next_Index;
    logic [UART_DATA_BITS-1:0] r_Shift, w_Next_Shift;
    logic [UART_DATA_BITS-1:0] r_Output_Byte, w_Next_Byte;
    logic                      r_RX_Valid, w_Next_Valid;
    logic                      r_Frame_Error, w_Next_Frame_Error;
    logic                      r_Parity_Error, w_Next_Parity_Error;
    logic                      r_Parity_Bad, w_Next_Parity_Bad;
    logic                      w_Bit_Done;

    assign w_Bit_Done = (r_Clock_Count == LAST_COUNT);

    always_comb begin
        w_Next_State        = r_State;
        w_Next_Count        = r_Clock_Count;
        w_Next_Index        = r_Bit_Index;
        w_Next_Shift        = r_Shift;
        w_Next_Byte         = r_Output_Byte;
        w_Next_Valid        = 1'b0;
        w_Next_Frame_Error  = 1'b0;
        w_Next_Parity_Error = 1'b0;
        w_Next_Parity_Bad   = r_Parity_Bad;

        case (r_State)
            IDLE: begin
                w_Next_Count = '0;
                w_Next_Index = '0;
                if (!w_RX_Sync) begin
                    w_Next_State = START_BIT;
                end
            end

            START_BIT: begin
                if (r_Clock_Count == HALF_BIT) begin
                    w_Next_Count = '0;
                    w_Next_State = w_RX_Sync ? IDLE : DATA_BIT;
                end else begin
                    w_Next_Count = r_Clock_Count + 16'd1;
                end
            end

            DATA_BIT: begin
                if (w_Bit_Done) begin
                    w_Next_Count               = '0;
                    w_Next_Shift[r_Bit_Index]  = w_RX_Sync;
                    if (r_Bit_Index == LAST_INDEX) begin
                        w_Next_Index = '0;
`ifdef UART_RX_PARITY_EN
                        w_Next_State = PARITY_BIT;
`else
                        w_Next_State = STOP_BIT;
`endif
                    end else begin
                        w_Next_Index = r_Bit_Index + 3'd1;
                    end
                end else begin
                    w_Next_Count = r_Clock_Count + 16'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY_BIT: begin
                if (w_Bit_Done) begin
                    w_Next_Count      = '0;
                    w_Next_Parity_Bad = (w_RX_Sync != calc_parity(r_Shift, 1'(PARITY_ODD)));
                    w_Next_State      = STOP_BIT;
                end else begin
                    w_Next_Count = r_Clock_Count + 16'd1;
                end
            end
`endif

            STOP_BIT: begin
                if (w_Bit_Done) begin
                    w_Next_Count = '0;
                    w_Next_State = CLEANUP;
                    if (w_RX_Sync) begin
                        w_Next_Byte         = r_Shift;
                        w_Next_Valid        = 1'b1;
                        w_Next_Parity_Error = r_Parity_Bad;
                    end else begin
                        w_Next_Frame_Error  = 1'b1;
                    end
                end else begin
                    w_Next_Count = r_Clock_Count + 16'd1;
                end
            end

            // A line held low (break) keeps us here; reset also lands here.
            CLEANUP: begin
                w_Next_Count = '0;
                w_Next_Index = '0;
                if (w_RX_Sync && w_Sync_Settled) begin
                    w_Next_State = IDLE;
                end
            end

            default: begin
                w_Next_Count = '0;
                w_Next_Index = '0;
                w_Next_State = CLEANUP;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State        <= CLEANUP;
            r_Clock_Count  <= '0;
            r_Bit_Index    <= '0;
            r_Shift        <= '0;
            r_Output_Byte  <= '0;
            r_RX_Valid     <= 1'b0;
            r_Frame_Error  <= 1'b0;
            r_Parity_Error <= 1'b0;
            r_Parity_Bad   <= 1'b0;
        end else begin
            r_State        <= w_Next_State;
            r_Clock_Count  <= w_Next_Count;
            r_Bit_Index    <= w_Next_Index;
            r_Shift        <= w_Next_Shift;
            r_Output_Byte  <= w_Next_Byte;
            r_RX_Valid     <= w_Next_Valid;
            r_Frame_Error  <= w_Next_Frame_Error;
            r_Parity_Error <= w_Next_Parity_Error;
            r_Parity_Bad   <= w_Next_Parity_Bad;
        end
    end

    assign o_Output_Byte    = r_Output_Byte;
    assign o_RX_Valid       = r_RX_Valid;
    assign o_Frame_Error    = r_Frame_Error;
    assign o_Main_RX_Active = (r_State == START_BIT) || (r_State == DATA_BIT) ||
                              (r_State == PARITY_BIT) || (r_State == STOP_BIT);
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Error   = r_Parity_Error;
`else
    assign o_Parity_Error   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized frame-level bench for uart_rx against a timing/event model
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int H    = (CPB - 1) / 2;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] out_byte;
    logic       valid, active, ferr, perr;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
        .i_Clock          (clk),
        .i_Reset          (rst),
        .i_RX_Serial      (rx),
        .o_Output_Byte    (out_byte),
        .o_RX_Valid       (valid),
        .o_Main_RX_Active (active),
        .o_Frame_Error    (ferr),
        .o_Parity_Error   (perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       v;
        logic       fe;
        logic       pe;
        logic [7:0] b;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc        = 0;
    int  active_cnt = 0;
    int  n_compared = 0;
    int  n_mismatch = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid || ferr || perr) obs_q.push_back('{cyc, valid, ferr, perr, out_byte});
        if (active) active_cnt <= active_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a frame starting at edge k0 reports at k0+3+H+FRAME_BITS*CPB.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        int   k0;
        logic pe;
        k0 = cyc + 1;
        pe = (par != ((^data) ^ PODD[0]));
        if (stop) begin
`ifdef UART_RX_PARITY_EN
            exp_q.push_back('{k0 + 3 + H + FRAME_BITS * CPB, 1'b1, 1'b0, pe, data});
`else
            exp_q.push_back('{k0 + 3 + H + FRAME_BITS * CPB, 1'b1, 1'b0, 1'b0, data});
`endif
            last_good = data;
        end else begin
            exp_q.push_back('{k0 + 3 + H + FRAME_BITS * CPB, 1'b0, 1'b1, 1'b0, last_good});
        end
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(data[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, CPB);
`endif
        drive_bit(stop, CPB);
    endtask

    initial begin
        int a0;
        logic [7:0] d;
        logic       s;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_byte",   out_byte, 8'h00);
        check("reset_valid",  valid, 1'b0);
        check("reset_active", active, 1'b0);
        check("reset_ferr",   ferr, 1'b0);
        check("reset_perr",   perr, 1'b0);
        rst = 1'b0;
        drive_bit(1'b1, 5);

        send_frame(8'hA5, 1'b1, 1'b0);
        drive_bit(1'b1, 10);

        a0 = active_cnt;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 3 * CPB);
        check("glitch_active_cycles", active_cnt - a0, H + 1);

        send_frame(8'h3C, 1'b0, 1'b0);
        a0 = active_cnt;
        drive_bit(1'b0, 50);
        check("break_active_cycles", active_cnt - a0, 0);
        drive_bit(1'b1, 2 * CPB);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        drive_bit(1'b1, CPB);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        drive_bit(1'b1, CPB);
`endif

        d = 8'h5A;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
        drive_bit(1'b0, 5);
        check("pre_reset_active", active, 1'b1);
        rst = 1'b1;
        #1;
        check("midreset_byte",   out_byte, 8'h00);
        check("midreset_valid",  valid, 1'b0);
        check("midreset_active", active, 1'b0);
        check("midreset_ferr",   ferr, 1'b0);
        check("midreset_perr",   perr, 1'b0);
        last_good = 8'h00;
        drive_bit(1'b0, 3);
        rst = 1'b0;
        a0 = active_cnt;
        drive_bit(1'b0, 40);
        check("stuck_low_active_cycles", active_cnt - a0, 0);
        drive_bit(1'b1, CPB);
        send_frame(8'h81, 1'b1, 1'b0);

        for (int f = 0; f < 24; f++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, s, 1'($urandom));
            if (s) drive_bit(1'b1, $urandom_range(0, 20));
            else   drive_bit(1'b1, $urandom_range(2, 20));
        end
        drive_bit(1'b1, 3 * CPB);

        check("event_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("ev%0d_cycle", i), obs_q[i].cyc, exp_q[i].cyc);
            check($sformatf("ev%0d_valid", i), obs_q[i].v,   exp_q[i].v);
            check($sformatf("ev%0d_ferr",  i), obs_q[i].fe,  exp_q[i].fe);
            check($sformatf("ev%0d_perr",  i), obs_q[i].pe,  exp_q[i].pe);
            check($sformatf("ev%0d_byte",  i), obs_q[i].b,   exp_q[i].b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
